// File: rtl/uart_frame_sched.sv
// Streams one frame (sync byte, 16-bit length, NUM_BYTES payload bytes) from frame memory into a UART transmitter.
// Define FRAME_CHECKSUM_EN to append an XOR checksum of the payload after the last payload byte.
module uart_frame_sched #(
    parameter int         NUM_BYTES = 4096,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    input  logic [7:0]        i_Rd_Data,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    localparam logic [15:0] LEN  = 16'(NUM_BYTES);
    localparam logic [15:0] LAST = 16'(NUM_BYTES - 1);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_RDWAIT, S_ISSUE, S_WAITTX, S_FINISH, S_CKSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_RDWAIT, S_ISSUE, S_WAITTX, S_FINISH
    } state_t;
`endif

    typedef enum logic [1:0] {P_HDR, P_PAY, P_CKS} phase_t;

    state_t              state, state_nx;
    phase_t              phase, phase_nx;
    logic [1:0]          hdr_idx, hdr_nx;
    logic [15:0]         cnt, cnt_nx;
    logic                done_q;
    logic                tx_dv, dv_nx;
    logic [7:0]          tx_byte, byte_nx;
    logic [ADDR_W-1:0]   rd_addr, addr_nx;
    logic                done_edge;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]          xor_acc, xor_nx;
`endif

    // A Done held high for several cycles must advance the sequence only once.
    assign done_edge = i_Tx_Done & ~done_q;

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        hdr_nx   = hdr_idx;
        cnt_nx   = cnt;
        dv_nx    = 1'b0;
        byte_nx  = tx_byte;
        addr_nx  = rd_addr;
`ifdef FRAME_CHECKSUM_EN
        xor_nx   = xor_acc;
`endif
        case (state)
            S_IDLE: begin
                if (i_Start) begin
                    state_nx = S_HDR;
                    phase_nx = P_HDR;
                    hdr_nx   = 2'd0;
`ifdef FRAME_CHECKSUM_EN
                    xor_nx   = 8'h00;
`endif
                end
            end
            S_HDR: begin
                case (hdr_idx)
                    2'd0:    byte_nx = SYNC_BYTE;
                    2'd1:    byte_nx = LEN[15:8];
                    default: byte_nx = LEN[7:0];
                endcase
                state_nx = S_ISSUE;
            end
            S_FETCH:  state_nx = S_RDWAIT;
            S_RDWAIT: begin
                byte_nx  = i_Rd_Data;
`ifdef FRAME_CHECKSUM_EN
                xor_nx   = xor_acc ^ i_Rd_Data;
`endif
                state_nx = S_ISSUE;
            end
            // Never strobe into a transmitter that is still busy or still signalling Done.
            S_ISSUE: begin
                if (!i_Tx_Active && !i_Tx_Done) begin
                    dv_nx    = 1'b1;
                    state_nx = S_WAITTX;
                end
            end
            S_WAITTX: begin
                if (done_edge) begin
                    case (phase)
                        P_HDR: begin
                            if (hdr_idx == 2'd2) begin
                                phase_nx = P_PAY;
                                addr_nx  = cnt[ADDR_W-1:0];
                                state_nx = S_FETCH;
                            end else begin
                                hdr_nx   = hdr_idx + 2'd1;
                                state_nx = S_HDR;
                            end
                        end
                        P_PAY: begin
                            cnt_nx = cnt + 16'd1;
                            if (cnt == LAST) begin
`ifdef FRAME_CHECKSUM_EN
                                phase_nx = P_CKS;
                                state_nx = S_CKSUM;
`else
                                state_nx = S_FINISH;
`endif
                            end else begin
                                // Address leads into FETCH so it is already valid there.
                                addr_nx  = cnt_nx[ADDR_W-1:0];
                                state_nx = S_FETCH;
                            end
                        end
                        default: state_nx = S_FINISH;
                    endcase
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CKSUM: begin
                byte_nx  = xor_acc;
                state_nx = S_ISSUE;
            end
`endif
            S_FINISH: begin
                cnt_nx   = 16'd0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state   <= S_IDLE;
            phase   <= P_HDR;
            hdr_idx <= 2'd0;
            cnt     <= 16'd0;
            done_q  <= 1'b0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
            rd_addr <= '0;
`ifdef FRAME_CHECKSUM_EN
            xor_acc <= 8'h00;
`endif
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            hdr_idx <= hdr_nx;
            cnt     <= cnt_nx;
            done_q  <= i_Tx_Done;
            tx_dv   <= dv_nx;
            tx_byte <= byte_nx;
            rd_addr <= addr_nx;
`ifdef FRAME_CHECKSUM_EN
            xor_acc <= xor_nx;
`endif
        end
    end

    assign o_Busy    = (state != S_IDLE);
    assign o_Done    = (state == S_FINISH);
    assign o_Tx_DV   = tx_dv & ~i_Reset;
    assign o_Tx_Byte = tx_byte;
    assign o_Rd_Addr = rd_addr;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench: two scheduler instances (4-byte and 300-byte frames), each feeding a behavioral UART transmitter.
module tb_uart_frame_sched;

    localparam int CPB = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB0 = 8;
    localparam int NB1 = 304;
`else
    localparam int NB0 = 7;
    localparam int NB1 = 303;
`endif

    logic       clk = 1'b0;
    logic       rst, start0, start1;
    int         hold;
    int         n_cmp = 0, n_bad = 0;

    logic       busy0, done0, dv0, act0 = 1'b0, txd0 = 1'b0;
    logic [1:0] addr0;
    logic [7:0] rd0, byte0;
    logic       busy1, done1, dv1, act1 = 1'b0, txd1 = 1'b0;
    logic [8:0] addr1;
    logic [7:0] rd1, byte1;

    logic [7:0] mem0 [4];
    logic [7:0] exp0 [8];

    always #5 clk = ~clk;

    uart_frame_sched #(.NUM_BYTES(4), .ADDR_W(2), .SYNC_BYTE(8'hAA)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start0), .o_Busy(busy0), .o_Done(done0),
        .o_Rd_Addr(addr0), .i_Rd_Data(rd0), .o_Tx_DV(dv0), .o_Tx_Byte(byte0),
        .i_Tx_Active(act0), .i_Tx_Done(txd0));

    uart_frame_sched #(.NUM_BYTES(300), .ADDR_W(9), .SYNC_BYTE(8'hAA)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start1), .o_Busy(busy1), .o_Done(done1),
        .o_Rd_Addr(addr1), .i_Rd_Data(rd1), .o_Tx_DV(dv1), .o_Tx_Byte(byte1),
        .i_Tx_Active(act1), .i_Tx_Done(txd1));

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) rd0 <= mem0[addr0];
    always @(posedge clk) rd1 <= addr1[7:0];

    // Behavioral transmitters: 10 bit times busy, then Done held for 'hold' cycles.
    int bc0 = 0, hc0 = 0, ncap0 = 0, ndv0 = 0, bad0 = 0, ndone0 = 0;
    logic [7:0] cap0 [1024];
    always @(posedge clk) begin
        if (done0) ndone0++;
        if (dv0) begin
            ndv0++;
            if (bc0 != 0 || txd0) bad0++;
            else begin
                cap0[ncap0[9:0]] = byte0;
                ncap0++;
                bc0 = 10 * CPB;
            end
        end else if (bc0 > 0) begin
            bc0--;
            if (bc0 == 0) hc0 = hold;
        end
        act0 <= (bc0 != 0);
        txd0 <= (hc0 != 0);
        if (hc0 > 0) hc0--;
    end

    int bc1 = 0, hc1 = 0, ncap1 = 0, ndv1 = 0, bad1 = 0, ndone1 = 0;
    logic [7:0] cap1 [1024];
    always @(posedge clk) begin
        if (done1) ndone1++;
        if (dv1) begin
            ndv1++;
            if (bc1 != 0 || txd1) bad1++;
            else begin
                cap1[ncap1[9:0]] = byte1;
                ncap1++;
                bc1 = 10 * CPB;
            end
        end else if (bc1 > 0) begin
            bc1--;
            if (bc1 == 0) hc1 = hold;
        end
        act1 <= (bc1 != 0);
        txd1 <= (hc1 != 0);
        if (hc1 > 0) hc1--;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done0); end
        n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL reset_dv got %b want 0", dv0); end
        n_cmp++; if (byte0 !== 8'h00) begin n_bad++; $display("FAIL reset_byte got %h want 00", byte0); end
        n_cmp++; if (addr0 !== 2'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", addr0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int base, d0;
        bit ok;
        hold = 1;
        base = ncap0; d0 = ndone0;
        pulse_start0();
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy0); end
        wait_done0(2000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout got %b want 1", ok); end
        n_cmp++; if (ncap0 - base !== NB0) begin n_bad++; $display("FAIL basic_count got %0d want %0d", ncap0 - base, NB0); end
        for (int i = 0; i < NB0; i++) begin
            n_cmp++;
            if (cap0[10'(base + i)] !== exp0[3'(i)]) begin
                n_bad++; $display("FAIL basic_byte%0d got %h want %h", i, cap0[10'(base + i)], exp0[3'(i)]);
            end
        end
        tick();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_drop got %b want 0", busy0); end
        n_cmp++; if (ndone0 - d0 !== 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d want 1", ndone0 - d0); end
    endtask

    task automatic test_done_hold();
        int base, v0, b0;
        bit ok;
        hold = 2;
        base = ncap0; v0 = ndv0; b0 = bad0;
        pulse_start0();
        wait_done0(2000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hold_timeout got %b want 1", ok); end
        n_cmp++; if (ndv0 - v0 !== NB0) begin n_bad++; $display("FAIL hold_dv_cnt got %0d want %0d", ndv0 - v0, NB0); end
        n_cmp++; if (bad0 - b0 !== 0) begin n_bad++; $display("FAIL hold_bad_dv got %0d want 0", bad0 - b0); end
        for (int i = 0; i < NB0; i++) begin
            n_cmp++;
            if (cap0[10'(base + i)] !== exp0[3'(i)]) begin
                n_bad++; $display("FAIL hold_byte%0d got %h want %h", i, cap0[10'(base + i)], exp0[3'(i)]);
            end
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int base, d0;
        bit ok;
        base = ncap0; d0 = ndone0;
        pulse_start0();
        repeat (200) tick();
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL swb_mid_busy got %b want 1", busy0); end
        pulse_start0();
        wait_done0(2000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL swb_timeout got %b want 1", ok); end
        // Start coinciding with o_Done must not open a new frame.
        pulse_start0();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL swb_start_at_done got %b want 0", busy0); end
        repeat (300) tick();
        n_cmp++; if (ncap0 - base !== NB0) begin n_bad++; $display("FAIL swb_count got %0d want %0d", ncap0 - base, NB0); end
        n_cmp++; if (ndone0 - d0 !== 1) begin n_bad++; $display("FAIL swb_done_cnt got %0d want 1", ndone0 - d0); end
    endtask

    task automatic test_reset_mid_frame();
        int base, b0, t;
        bit ok;
        hold = 1;
        base = ncap0; b0 = bad0;
        pulse_start0();
        t = 0;
        while (ncap0 - base < 5 && t < 1000) begin tick(); t++; end
        n_cmp++; if (ncap0 - base !== 5) begin n_bad++; $display("FAIL rmf_reach got %0d want 5", ncap0 - base); end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rmf_busy got %b want 0", busy0); end
        n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL rmf_dv got %b want 0", dv0); end
        n_cmp++; if (byte0 !== 8'h00) begin n_bad++; $display("FAIL rmf_byte got %h want 00", byte0); end
        n_cmp++; if (addr0 !== 2'd0) begin n_bad++; $display("FAIL rmf_addr got %0d want 0", addr0); end
        rst = 1'b0;
        // Restart while byte 02 is still on the line; the first DV must wait for it.
        pulse_start0();
        wait_done0(2000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmf_timeout got %b want 1", ok); end
        n_cmp++; if (ncap0 - base !== 5 + NB0) begin n_bad++; $display("FAIL rmf_count got %0d want %0d", ncap0 - base, 5 + NB0); end
        n_cmp++; if (cap0[10'(base + 5)] !== 8'hAA) begin n_bad++; $display("FAIL rmf_first got %h want aa", cap0[10'(base + 5)]); end
        n_cmp++; if (bad0 - b0 !== 0) begin n_bad++; $display("FAIL rmf_bad_dv got %0d want 0", bad0 - b0); end
        tick();
    endtask

    task automatic test_addr_sweep();
        bit ok;
        ok = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (done1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sweep_timeout got %b want 1", ok); end
        n_cmp++; if (ncap1 !== NB1) begin n_bad++; $display("FAIL sweep_count got %0d want %0d", ncap1, NB1); end
        n_cmp++; if (cap1[0] !== 8'hAA) begin n_bad++; $display("FAIL sweep_sync got %h want aa", cap1[0]); end
        n_cmp++; if (cap1[1] !== 8'h01) begin n_bad++; $display("FAIL sweep_len_hi got %h want 01", cap1[1]); end
        n_cmp++; if (cap1[2] !== 8'h2C) begin n_bad++; $display("FAIL sweep_len_lo got %h want 2c", cap1[2]); end
        for (int i = 0; i < 300; i++) begin
            n_cmp++;
            if (cap1[10'(3 + i)] !== 8'(i)) begin
                n_bad++; $display("FAIL sweep_pay%0d got %h want %h", i, cap1[10'(3 + i)], 8'(i));
            end
        end
`ifdef FRAME_CHECKSUM_EN
        n_cmp++; if (cap1[303] !== 8'h00) begin n_bad++; $display("FAIL sweep_cksum got %h want 00", cap1[303]); end
`endif
        n_cmp++; if (addr1 !== 9'd299) begin n_bad++; $display("FAIL sweep_last_addr got %0d want 299", addr1); end
        tick();
        n_cmp++; if (ndone1 !== 1) begin n_bad++; $display("FAIL sweep_done_cnt got %0d want 1", ndone1); end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; hold = 1;
        mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h03; mem0[3] = 8'h04;
        exp0[0] = 8'hAA; exp0[1] = 8'h00; exp0[2] = 8'h04; exp0[3] = 8'h01;
        exp0[4] = 8'h02; exp0[5] = 8'h03; exp0[6] = 8'h04; exp0[7] = 8'h04;
        test_reset();
        test_basic_frame();
        test_done_hold();
        test_start_while_busy();
        test_reset_mid_frame();
        test_addr_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
